writeback_arbiter: RTL
======================

Name: writeback_arbiter

Overview:
- Writeback stage directly upstream of register_file. Merges two result producers into the single register_file write port (reg_write, write_register, write_data):
  - the single-cycle ALU path;
  - the variable-latency load-return path.
- Load returns are buffered in a small FIFO.
- A per-register pending-load scoreboard is kept for the issue stage's hazard checks.

Parameters:
- NUM_REGS, 32, number of architectural registers; register index width is clog2(NUM_REGS).
- DATA_WIDTH, 64, result width in bits.
- LQ_DEPTH, 4, load-return FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
- alu_rd  in  clog2(NUM_REGS)  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- ld_valid  in  1  load return present.
- ld_ready  out  1  load return accepted this cycle when ld_valid is also high.
- ld_rd  in  clog2(NUM_REGS)  load destination register.
- ld_data  in  DATA_WIDTH  load data.
- issue_valid  in  1  a load is being issued this cycle.
- issue_rd  in  clog2(NUM_REGS)  destination register of the issued load.
- busy  out  NUM_REGS  pending-load bit per register.
- reg_write  out  1  write enable to register_file.
- write_register  out  clog2(NUM_REGS)  write index to register_file.
- write_data  out  DATA_WIDTH  write data to register_file.

Behaviour:
- Reset (asynchronous assert, synchronous release on the clk edge after rst falls):
  - FIFO emptied; any queued load returns are discarded.
  - busy = 0, reg_write = 0, write_register = 0, write_data = 0.
  - alu_ready and ld_ready are 0 while rst is high.
- Handshakes:
  - ld_ready = !fifo_full. Combinational from state only, never from the valids.
  - alu_ready = !fifo_full.
  - A transfer occurs on a rising edge where valid && ready.
  - Producers hold rd and data stable while valid && !ready.
- Arbitration, at most one commit per cycle:
  - FIFO full: commit the FIFO head; ALU and load are both stalled.
  - Otherwise, alu_valid high: commit the ALU result.
  - Otherwise, FIFO non-empty: commit the FIFO head.
  - Otherwise: no commit.
- Load path:
  - An accepted load is always pushed into the FIFO; it never bypasses the FIFO.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Pointers wrap modulo LQ_DEPTH.
  - FIFO order is preserved.
- Output register:
  - On a commit edge: write_register <= rd, write_data <= data, reg_write <= (rd != 0).
  - On a non-commit edge: reg_write <= 0; write_register and write_data hold their values.
  - Writes to x0 are consumed (handshake completes) but never drive reg_write.
- Latency:
  - ALU accepted at edge k: reg_write is high in the cycle after edge k (latency 1).
  - Load accepted at edge k into an empty FIFO with no alu_valid at edge k+1: reg_write is high after edge k+1 (minimum latency 2).
- Scoreboard:
  - Set: busy[issue_rd] <= 1 on issue_valid && issue_rd != 0.
  - Clear: busy[rd] <= 0 when a FIFO-head commit writes rd.
  - Set and clear of the same rd in the same cycle: set wins.
  - ALU commits never change busy.
  - busy[0] is always 0.
- Not checked: a load return without a matching issue and WAW ordering; both are the issue stage's responsibility.

Test Plan:
- Reset mid-operation:
  - Stimulus: push 3 loads, assert rst asynchronously between edges.
  - Required: reg_write, busy, write_register and write_data go to 0 immediately; after release the FIFO is empty (no stale commits) and ld_ready = 1.
- ALU only:
  - Stimulus: alu_rd=5, alu_data=64'hDEAD_BEEF_0000_0001 accepted at edge k.
  - Required: reg_write=1, write_register=5, write_data=64'hDEAD_BEEF_0000_0001 for exactly one cycle after edge k. A register_file read of x5 then returns that value.
- x0 suppression:
  - Stimulus: ALU alu_rd=0, data 64'hFFFF; then load ld_rd=0.
  - Required: both handshakes complete; reg_write stays 0 throughout.
- Simultaneous ALU and load:
  - Stimulus: issue_rd=7, then alu(rd=3, 64'h11) and ld(rd=7, 64'h22) valid at the same edge.
  - Required: x3 written first; x7 written the next cycle; busy[7] goes 1 to 0 on the x7 commit edge.
- FIFO full and wrap:
  - Stimulus: alu_valid held high with rd=1..; 4 loads rd=10..13 pushed.
  - Required: ld_ready=0 once 4 entries are queued; alu_ready=0 in that cycle; the head (rd=10) commits; order 10,11,12,13 is preserved across pointer wrap with 6 further loads.
- Scoreboard race:
  - Stimulus: issue_valid with issue_rd=9 on the same edge that the FIFO head rd=9 commits.
  - Required: busy[9] remains 1; a later load commit to 9 clears it.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
// Writeback bundle: ALU and load-return producers, load-issue notification,
// pending-load scoreboard and the register_file write port.
interface writeback_arbiter_if #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 64
);
    localparam int RW = $clog2(NUM_REGS);

    logic                  alu_valid;
    logic                  alu_ready;
    logic [RW-1:0]         alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [RW-1:0]         ld_rd;
    logic [DATA_WIDTH-1:0] ld_data;

    logic                  issue_valid;
    logic [RW-1:0]         issue_rd;
    logic [NUM_REGS-1:0]   busy;

    logic                  reg_write;
    logic [RW-1:0]         write_register;
    logic [DATA_WIDTH-1:0] write_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  issue_valid, issue_rd,
        output alu_ready, ld_ready, busy,
        output reg_write, write_register, write_data
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output issue_valid, issue_rd,
        input  alu_ready, ld_ready, busy,
        input  reg_write, write_register, write_data
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges the ALU result path and a FIFO-buffered load-return path into the
// single register_file write port, and tracks pending loads per register.
module writeback_arbiter #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LQ_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    writeback_arbiter_if.slave wb
);
    localparam int          RW       = $clog2(NUM_REGS);
    localparam int          AW       = $clog2(LQ_DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(LQ_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // Load-return queue storage; contents are don't-care while the queue is empty.
    logic [RW-1:0]         lq_rd_mem   [LQ_DEPTH];
    logic [DATA_WIDTH-1:0] lq_data_mem [LQ_DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  reg_write_q, reg_write_d;
    logic [RW-1:0]         write_register_q, write_register_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept_ok;
    logic                  alu_commit;
    logic                  push;
    logic                  pop;
    logic [RW-1:0]         commit_rd;
    logic [DATA_WIDTH-1:0] commit_data;

    // Arbitration: a full queue drains first, then ALU, then any queued load.
    always_comb begin
        fifo_full   = (count_q == CNT_FULL);
        fifo_empty  = (count_q == '0);
        accept_ok   = !rst && !fifo_full;
        alu_commit  = wb.alu_valid && !fifo_full;
        pop         = !alu_commit && !fifo_empty;
        push        = wb.ld_valid && accept_ok;
        commit_rd   = alu_commit ? wb.alu_rd   : lq_rd_mem[rd_ptr_q];
        commit_data = alu_commit ? wb.alu_data : lq_data_mem[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Issue-side set is applied after the commit-side clear so it wins a race.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[commit_rd] = 1'b0;
        end
        if (wb.issue_valid && (wb.issue_rd != '0)) begin
            busy_d[wb.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        reg_write_d      = 1'b0;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        if (alu_commit || pop) begin
            reg_write_d      = (commit_rd != '0);
            write_register_d = commit_rd;
            write_data_d     = commit_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            busy_q           <= '0;
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            busy_q           <= busy_d;
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd_mem[wr_ptr_q]   <= wb.ld_rd;
            lq_data_mem[wr_ptr_q] <= wb.ld_data;
        end
    end

    assign wb.alu_ready      = accept_ok;
    assign wb.ld_ready       = accept_ok;
    assign wb.busy           = busy_q;
    assign wb.reg_write      = reg_write_q;
    assign wb.write_register = write_register_q;
    assign wb.write_data     = write_data_q;
endmodule
